// File: rtl/pattern_rx_if.sv
// pattern_rx_if -- serial pattern receiver bus.
// Carries the serial input, frame qualifier and received-pattern outputs.
// The compare signals (exp_pat, clr_cnt, match, err_cnt) exist only when
// PATTERN_RX_CMP_EN is defined.
interface pattern_rx_if;
  logic        rx_in;
  logic        rx_frame;
  logic [7:0]  pat_out;
  logic        pat_valid;
  logic        busy;
  logic        frame_err;
`ifdef PATTERN_RX_CMP_EN
  logic [7:0]  exp_pat;
  logic        clr_cnt;
  logic        match;
  logic [15:0] err_cnt;
`endif

  // Driver side: produces the serial stream, observes the results.
  modport master (
    output rx_in, rx_frame,
`ifdef PATTERN_RX_CMP_EN
    output exp_pat, clr_cnt,
    input  match, err_cnt,
`endif
    input  pat_out, pat_valid, busy, frame_err
  );

  // Receiver side: the pattern_rx block itself.
  modport slave (
    input  rx_in, rx_frame,
`ifdef PATTERN_RX_CMP_EN
    input  exp_pat, clr_cnt,
    output match, err_cnt,
`endif
    output pat_out, pat_valid, busy, frame_err
  );
endinterface

// File: rtl/pattern_rx.sv
// pattern_rx -- 8-bit LSB-first serial pattern receiver.
// A frame is rx_frame high for 8 cycles; the assembled byte is published on
// pat_out with a one-cycle pat_valid pulse. Short and overlong frames raise a
// one-cycle frame_err pulse. Optional feature macro PATTERN_RX_CMP_EN adds a
// registered compare against exp_pat and a saturating mismatch counter.
module pattern_rx (
  input  logic        clk,
  input  logic        rst,
  pattern_rx_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] pat_out_q, pat_out_d;
  logic       pat_valid_q, pat_valid_d;
  logic       frame_err_q, frame_err_d;
  // Remembers that the current overlong frame has already been flagged.
  logic       ovl_seen_q, ovl_seen_d;
  // High in the cycle whose edge completes a pattern.
  logic       pat_done;

  // Next-state, shift register and output pulse decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    pat_out_d   = pat_out_q;
    pat_valid_d = 1'b0;
    frame_err_d = 1'b0;
    ovl_seen_d  = ovl_seen_q;
    pat_done    = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d  = 3'd0;
        ovl_seen_d = 1'b0;
        if (bus.rx_frame) begin
          shift_d   = {7'd0, bus.rx_in};
          bit_cnt_d = 3'd1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.rx_frame) begin
          shift_d[bit_cnt_q] = bus.rx_in;
          // Wraps to 0 after bit 7, so HOLD starts with a cleared counter.
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            pat_out_d   = shift_d;
            pat_valid_d = 1'b1;
            pat_done    = 1'b1;
            state_d     = HOLD;
          end
        end else begin
          // Frame ended early: drop the partial byte, keep pat_out.
          frame_err_d = 1'b1;
          shift_d     = 8'd0;
          bit_cnt_d   = 3'd0;
          state_d     = IDLE;
        end
      end

      HOLD: begin
        if (bus.rx_frame) begin
          // Overlong frame: flag once, ignore the extra bits.
          frame_err_d = ~ovl_seen_q;
          ovl_seen_d  = 1'b1;
        end else begin
          ovl_seen_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        bit_cnt_d  = 3'd0;
        ovl_seen_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the shift register is a handful of flops, not a memory, so it
      // is reset along with the rest of the state.
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      pat_out_q   <= 8'h00;
      pat_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      ovl_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pat_out_q   <= pat_out_d;
      pat_valid_q <= pat_valid_d;
      frame_err_q <= frame_err_d;
      ovl_seen_q  <= ovl_seen_d;
    end
  end

  assign bus.pat_out   = pat_out_q;
  assign bus.pat_valid = pat_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef PATTERN_RX_CMP_EN
  logic        match_q, match_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Compare the freshly completed pattern; clear beats a simultaneous count.
  always_comb begin
    match_d   = match_q;
    err_cnt_d = err_cnt_q;
    if (pat_done) begin
      match_d = (pat_out_d == bus.exp_pat);
      if ((pat_out_d != bus.exp_pat) && (err_cnt_q != 16'hFFFF))
        err_cnt_d = err_cnt_q + 16'd1;
    end
    if (bus.clr_cnt)
      err_cnt_d = 16'h0000;
  end

  // Compare result and mismatch counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q   <= 1'b0;
      err_cnt_q <= 16'h0000;
    end else begin
      match_q   <= match_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.match   = match_q;
  assign bus.err_cnt = err_cnt_q;
`else
  // Compare feature not built: pat_done only feeds the compare logic.
  logic unused_pat_done;
  assign unused_pat_done = pat_done;
`endif

endmodule

// File: tb/tb_pattern_rx.sv
// tb_pattern_rx -- self-checking bench for pattern_rx.
// Stimulus is queued per cycle; a frame-level model derives the expected
// pulses and pattern from run lengths of rx_frame before the queue is played.
// Compare checks are included when PATTERN_RX_CMP_EN is defined.
module tb_pattern_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pattern_rx_if bus ();

  pattern_rx u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Per-cycle stimulus queues.
  logic       q_frame[$];
  logic       q_bit[$];
  logic [7:0] q_exp[$];
  logic       q_clr[$];
  logic [7:0] cur_exp = 8'h00;

  // Model state carried across scenarios.
  logic [7:0]  m_pat   = 8'h00;
  logic        m_match = 1'b0;
  logic [15:0] m_err   = 16'h0000;

  task automatic add_frame(input logic [7:0] pat, input int len, input logic clr_last);
    for (int j = 0; j < len; j++) begin
      q_frame.push_back(1'b1);
      q_bit.push_back(j < 8 ? pat[j] : 1'($urandom_range(0, 1)));
      q_exp.push_back(cur_exp);
      q_clr.push_back(clr_last && (j == 7));
    end
  endtask

  task automatic add_idle(input int n, input logic rnd_clr);
    for (int j = 0; j < n; j++) begin
      q_frame.push_back(1'b0);
      q_bit.push_back(1'($urandom_range(0, 1)));
      q_exp.push_back(cur_exp);
      q_clr.push_back(rnd_clr && ($urandom_range(0, 7) == 0));
    end
  endtask

  // Play the queued cycles and compare every output after each edge.
  task automatic run_seq(input string name);
    int         n;
    int         i;
    int         s;
    int         len;
    logic       e_valid[];
    logic       e_err[];
    logic       e_busy[];
    logic [7:0] e_pat[];
    n = q_frame.size();
    e_valid = new[n];
    e_err   = new[n];
    e_busy  = new[n];
    e_pat   = new[n];
    for (int c = 0; c < n; c++) begin
      e_valid[c] = 1'b0;
      e_err[c]   = 1'b0;
      e_busy[c]  = 1'b0;
      e_pat[c]   = 8'h00;
    end
    // Frame-level model: a run of L frame cycles starting at s is busy for
    // L cycles; L>=8 delivers bits s..s+7 one cycle later, L>8 flags once,
    // L<8 flags when the qualifier drops.
    i = 0;
    while (i < n) begin
      if (q_frame[i]) begin
        s = i;
        while (i < n && q_frame[i]) i++;
        len = i - s;
        for (int k = s; k < s + len; k++) e_busy[k] = 1'b1;
        if (len >= 8) begin
          e_valid[s + 7] = 1'b1;
          for (int b = 0; b < 8; b++) e_pat[s + 7][b] = q_bit[s + b];
          if (len > 8 && s + 8 < n) e_err[s + 8] = 1'b1;
        end else if (s + len < n) begin
          e_err[s + len] = 1'b1;
        end
      end else begin
        i++;
      end
    end

    for (int c = 0; c < n; c++) begin
      bus.rx_frame = q_frame[c];
      bus.rx_in    = q_bit[c];
`ifdef PATTERN_RX_CMP_EN
      bus.exp_pat  = q_exp[c];
      bus.clr_cnt  = q_clr[c];
`endif
      @(posedge clk);
      #1;
      if (e_valid[c]) begin
        m_pat   = e_pat[c];
        m_match = (e_pat[c] == q_exp[c]);
        if (!m_match && m_err != 16'hFFFF) m_err = m_err + 16'd1;
      end
      if (q_clr[c]) m_err = 16'h0000;

      n_checks++;
      if (bus.pat_valid !== e_valid[c]) begin
        n_errors++;
        $display("FAIL %s cyc %0d pat_valid: got %b exp %b", name, c, bus.pat_valid, e_valid[c]);
      end
      n_checks++;
      if (bus.frame_err !== e_err[c]) begin
        n_errors++;
        $display("FAIL %s cyc %0d frame_err: got %b exp %b", name, c, bus.frame_err, e_err[c]);
      end
      n_checks++;
      if (bus.busy !== e_busy[c]) begin
        n_errors++;
        $display("FAIL %s cyc %0d busy: got %b exp %b", name, c, bus.busy, e_busy[c]);
      end
      n_checks++;
      if (bus.pat_out !== m_pat) begin
        n_errors++;
        $display("FAIL %s cyc %0d pat_out: got %h exp %h", name, c, bus.pat_out, m_pat);
      end
`ifdef PATTERN_RX_CMP_EN
      n_checks++;
      if (bus.match !== m_match) begin
        n_errors++;
        $display("FAIL %s cyc %0d match: got %b exp %b", name, c, bus.match, m_match);
      end
      n_checks++;
      if (bus.err_cnt !== m_err) begin
        n_errors++;
        $display("FAIL %s cyc %0d err_cnt: got %h exp %h", name, c, bus.err_cnt, m_err);
      end
`endif
    end
    q_frame.delete();
    q_bit.delete();
    q_exp.delete();
    q_clr.delete();
  endtask

  // Checks that every output sits at its reset value.
  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (bus.pat_out !== 8'h00 || bus.pat_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: got pat_out=%h pat_valid=%b busy=%b frame_err=%b exp 00/0/0/0",
               name, bus.pat_out, bus.pat_valid, bus.busy, bus.frame_err);
    end
`ifdef PATTERN_RX_CMP_EN
    n_checks++;
    if (bus.match !== 1'b0 || bus.err_cnt !== 16'h0000) begin
      n_errors++;
      $display("FAIL %s: got match=%b err_cnt=%h exp 0/0000", name, bus.match, bus.err_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.rx_frame = 1'b1;
    bus.rx_in    = 1'b1;
`ifdef PATTERN_RX_CMP_EN
    bus.exp_pat  = 8'h00;
    bus.clr_cnt  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst          = 1'b0;
    bus.rx_frame = 1'b0;
    m_pat = 8'h00; m_match = 1'b0; m_err = 16'h0000;
  endtask

  task automatic test_nominal();
    add_idle(1, 1'b0);
    add_frame(8'hA5, 8, 1'b0);
    add_idle(2, 1'b0);
    run_seq("nominal_a5");
  endtask

  task automatic test_short_frame();
    add_frame(8'h5C, 5, 1'b0);
    add_idle(2, 1'b0);
    run_seq("short_5");
  endtask

  task automatic test_overlong();
    add_frame(8'h3C, 10, 1'b0);
    add_idle(2, 1'b0);
    run_seq("overlong_3c");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] p;
    p = 8'hE7;
    for (int j = 0; j < 4; j++) begin
      bus.rx_frame = 1'b1;
      bus.rx_in    = p[j];
      @(posedge clk);
      #1;
    end
    rst       = 1'b1;
    bus.rx_in = p[4];
    @(posedge clk);
    #1;
    check_reset_outputs("reset_midframe");
    m_pat = 8'h00; m_match = 1'b0; m_err = 16'h0000;
    rst = 1'b0;
    add_idle(1, 1'b0);
    add_frame(8'h81, 8, 1'b0);
    add_idle(2, 1'b0);
    run_seq("after_reset_81");
  endtask

  task automatic test_back_to_back();
    add_frame(8'h01, 8, 1'b0);
    add_idle(1, 1'b0);
    add_frame(8'h80, 8, 1'b0);
    add_idle(2, 1'b0);
    run_seq("back_to_back");
  endtask

  task automatic test_compare();
    cur_exp = 8'h5A;
    add_frame(8'h5A, 8, 1'b0);
    add_idle(1, 1'b0);
    add_frame(8'hFF, 8, 1'b0);
    add_idle(1, 1'b0);
    add_frame(8'h00, 8, 1'b1);
    add_idle(2, 1'b0);
    run_seq("compare");
  endtask

  task automatic test_random();
    logic [7:0] p;
    for (int f = 0; f < 60; f++) begin
      p       = 8'($urandom);
      cur_exp = ($urandom_range(0, 1) == 1) ? p : 8'($urandom);
      add_frame(p, $urandom_range(1, 11), 1'b0);
      add_idle($urandom_range(1, 3), 1'b1);
    end
    run_seq("random");
  endtask

  initial begin
    bus.rx_frame = 1'b0;
    bus.rx_in    = 1'b0;
    test_reset();
    test_nominal();
    test_short_frame();
    test_overlong();
    test_reset_midframe();
    test_back_to_back();
    test_compare();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
